// File: rtl/datapath_pkg.sv
// Shared opcode values, ALU operation encoding and opcode classification helpers
// for the forwarding 5-stage datapath.
package datapath_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_LDM = 4'h0;
  localparam logic [OP_W-1:0] OP_STM = 4'h1;
  localparam logic [OP_W-1:0] OP_LDR = 4'h2;
  localparam logic [OP_W-1:0] OP_MOV = 4'h3;
  localparam logic [OP_W-1:0] OP_AND = 4'h4;
  localparam logic [OP_W-1:0] OP_OR  = 4'h5;
  localparam logic [OP_W-1:0] OP_XOR = 4'h6;
  localparam logic [OP_W-1:0] OP_NOT = 4'h7;
  localparam logic [OP_W-1:0] OP_SHL = 4'h8;
  localparam logic [OP_W-1:0] OP_SHR = 4'h9;
  localparam logic [OP_W-1:0] OP_ADD = 4'hA;
  localparam logic [OP_W-1:0] OP_SUB = 4'hB;
  localparam logic [OP_W-1:0] OP_DIV = 4'hC;

  typedef enum logic [3:0] {
    ALU_PASSA, ALU_PASSB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_NEG,
    ALU_SHL, ALU_SHR, ALU_SRA, ALU_ADD, ALU_SUB, ALU_DIV
  } alu_op_e;

  function automatic logic isAluOp(input logic [OP_W-1:0] op);
    return (op >= OP_AND) && (op <= OP_DIV);
  endfunction

  // ldm, ldr, mov and every ALU op write rd; stm and the D-F nops do not
  function automatic logic writesReg(input logic [OP_W-1:0] op);
    return (op == OP_LDM) || (op == OP_LDR) || (op == OP_MOV) || isAluOp(op);
  endfunction

  function automatic logic readsRs1(input logic [OP_W-1:0] op);
    return (op == OP_MOV) || isAluOp(op);
  endfunction

  function automatic logic readsRs2(input logic [OP_W-1:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR) ||
           (op == OP_ADD) || (op == OP_SUB) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU for the EX stage; divide by zero yields all-ones and raises div0.
module dp_alu import datapath_pkg::*; #(
  parameter int DATA_W = 16
) (
  input  alu_op_e           i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_res,
  output logic              o_div0
);

  always_comb begin
    o_res  = '0;
    o_div0 = 1'b0;
    case (i_op)
      ALU_PASSA: o_res = i_a;
      ALU_PASSB: o_res = i_b;
      ALU_AND:   o_res = i_a & i_b;
      ALU_OR:    o_res = i_a | i_b;
      ALU_XOR:   o_res = i_a ^ i_b;
      ALU_NOT:   o_res = ~i_a;
      ALU_NEG:   o_res = -i_a;
      ALU_SHL:   o_res = i_a << i_b;
      ALU_SHR:   o_res = i_a >> i_b;
      ALU_SRA:   o_res = $signed(i_a) >>> i_b;
      ALU_ADD:   o_res = i_a + i_b;
      ALU_SUB:   o_res = i_a - i_b;
      ALU_DIV: begin
        if (i_b == '0) begin
          o_res  = '1;
          o_div0 = 1'b1;
        end else begin
          o_res = i_a / i_b;
        end
      end
      default:   o_res = '0;
    endcase
  end

endmodule

// File: rtl/pipelined_datapath_fwd.sv
// 5-stage IF/ID/EX/MEM/WB datapath with EX operand forwarding, a one-cycle
// load-use bubble, an external synchronous data-memory port and a retire port.
module pipelined_datapath_fwd import datapath_pkg::*; #(
  parameter  int DATA_W  = 16,
  parameter  int REG_AW  = 4,
  parameter  int MEM_AW  = 8,
  localparam int INSTR_W = 4 + 3*REG_AW
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic               mem_we,
  output logic               mem_re,
  output logic [MEM_AW-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               retire_valid,
  output logic [REG_AW-1:0]  retire_rd,
  output logic [DATA_W-1:0]  retire_data,
  output logic               zero_flag,
  output logic               error_flag,
  output logic               stall
);

  localparam int IMM_W = 2*REG_AW;
  localparam int NREG  = 2**REG_AW;

  logic [DATA_W-1:0]  r_regs [NREG];

  logic               r_ifid_valid;
  logic [INSTR_W-1:0] r_ifid_instr;

  logic               r_idex_valid;
  logic [OP_W-1:0]    r_idex_op;
  logic [REG_AW-1:0]  r_idex_rd, r_idex_srcA, r_idex_srcB;
  logic [DATA_W-1:0]  r_idex_valA, r_idex_valB, r_idex_imm;
  alu_op_e            r_idex_aluOp;
  logic               r_idex_useImm;
  logic [MEM_AW-1:0]  r_idex_addr;

  logic               r_exmem_valid;
  logic [OP_W-1:0]    r_exmem_op;
  logic [REG_AW-1:0]  r_exmem_rd;
  logic [DATA_W-1:0]  r_exmem_result;
  logic [MEM_AW-1:0]  r_exmem_addr;
  logic               r_exmem_div0;

  logic               r_memwb_valid;
  logic [OP_W-1:0]    r_memwb_op;
  logic [REG_AW-1:0]  r_memwb_rd;
  logic [DATA_W-1:0]  r_memwb_result;
  logic               r_memwb_div0;

  logic               r_zero, r_error;

  logic [OP_W-1:0]    w_op;
  logic [REG_AW-1:0]  w_rd, w_rs1, w_rs2, w_srcA;
  logic [IMM_W-1:0]   w_imm;
  logic               w_readA, w_readB, w_loadUse;
  alu_op_e            w_aluOp;
  logic               w_useImm;
  logic [DATA_W-1:0]  w_immVal, w_rfA, w_rfB;
  logic [DATA_W-1:0]  w_fwdA, w_fwdB, w_aluB, w_aluRes, w_wbData;
  logic               w_aluDiv0, w_exmemFwd, w_wbWrite;

  assign w_op   = r_ifid_instr[INSTR_W-1 -: OP_W];
  assign w_rd   = r_ifid_instr[3*REG_AW-1 -: REG_AW];
  assign w_rs1  = r_ifid_instr[2*REG_AW-1 -: REG_AW];
  assign w_rs2  = r_ifid_instr[REG_AW-1:0];
  assign w_imm  = r_ifid_instr[IMM_W-1:0];
  // stm carries its store data in rd, so it travels down the rs1 operand path
  assign w_srcA = (w_op == OP_STM) ? w_rd : w_rs1;
  assign w_readA = readsRs1(w_op) || (w_op == OP_STM);
  assign w_readB = readsRs2(w_op);

  always_comb begin
    w_aluOp  = ALU_PASSA;
    w_useImm = 1'b0;
    w_immVal = '0;
    case (w_op)
      OP_LDR: begin
        w_aluOp  = ALU_PASSB;
        w_useImm = 1'b1;
        w_immVal = DATA_W'(w_imm);
      end
      OP_AND: w_aluOp = ALU_AND;
      OP_OR:  w_aluOp = ALU_OR;
      OP_XOR: w_aluOp = ALU_XOR;
      OP_NOT: w_aluOp = (w_rs2 == '1) ? ALU_NEG : ALU_NOT;
      OP_SHL: begin
        w_aluOp  = ALU_SHL;
        w_useImm = 1'b1;
        w_immVal = DATA_W'(w_rs2[REG_AW-2:0]);
      end
      OP_SHR: begin
        w_aluOp  = w_rs2[REG_AW-1] ? ALU_SRA : ALU_SHR;
        w_useImm = 1'b1;
        w_immVal = DATA_W'(w_rs2[REG_AW-2:0]);
      end
      OP_ADD: w_aluOp = ALU_ADD;
      OP_SUB: w_aluOp = ALU_SUB;
      OP_DIV: w_aluOp = ALU_DIV;
      default: w_aluOp = ALU_PASSA;
    endcase
  end

  assign w_wbData  = (r_memwb_op == OP_LDM) ? mem_rdata : r_memwb_result;
  assign w_wbWrite = r_memwb_valid && writesReg(r_memwb_op);

  assign w_rfA = (w_wbWrite && r_memwb_rd == w_srcA) ? w_wbData : r_regs[w_srcA];
  assign w_rfB = (w_wbWrite && r_memwb_rd == w_rs2)  ? w_wbData : r_regs[w_rs2];

  assign w_loadUse = r_ifid_valid && r_idex_valid && (r_idex_op == OP_LDM) &&
                     ((w_readA && w_srcA == r_idex_rd) || (w_readB && w_rs2 == r_idex_rd));

  assign w_exmemFwd = r_exmem_valid && writesReg(r_exmem_op);
  assign w_fwdA = (w_exmemFwd && r_exmem_rd == r_idex_srcA) ? r_exmem_result :
                  (w_wbWrite  && r_memwb_rd == r_idex_srcA) ? w_wbData : r_idex_valA;
  assign w_fwdB = (w_exmemFwd && r_exmem_rd == r_idex_srcB) ? r_exmem_result :
                  (w_wbWrite  && r_memwb_rd == r_idex_srcB) ? w_wbData : r_idex_valB;
  assign w_aluB = r_idex_useImm ? r_idex_imm : w_fwdB;

  dp_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op   (r_idex_aluOp),
    .i_a    (w_fwdA),
    .i_b    (w_aluB),
    .o_res  (w_aluRes),
    .o_div0 (w_aluDiv0)
  );

  assign instr_ready  = !reset && !w_loadUse;
  assign stall        = !reset && w_loadUse;
  assign mem_we       = !reset && r_exmem_valid && (r_exmem_op == OP_STM);
  assign mem_re       = !reset && r_exmem_valid && (r_exmem_op == OP_LDM);
  assign mem_addr     = r_exmem_addr;
  assign mem_wdata    = r_exmem_result;
  assign retire_valid = !reset && r_memwb_valid;
  assign retire_rd    = (!reset && w_wbWrite) ? r_memwb_rd : '0;
  assign retire_data  = (!reset && w_wbWrite) ? w_wbData : '0;
  assign zero_flag    = !reset && r_zero;
  assign error_flag   = !reset && r_error;

  // During a load-use bubble IF/ID holds and ID/EX takes an invalid slot
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ifid_valid   <= 1'b0;
      r_ifid_instr   <= '0;
      r_idex_valid   <= 1'b0;
      r_idex_op      <= '0;
      r_idex_rd      <= '0;
      r_idex_srcA    <= '0;
      r_idex_srcB    <= '0;
      r_idex_valA    <= '0;
      r_idex_valB    <= '0;
      r_idex_imm     <= '0;
      r_idex_aluOp   <= ALU_PASSA;
      r_idex_useImm  <= 1'b0;
      r_idex_addr    <= '0;
      r_exmem_valid  <= 1'b0;
      r_exmem_op     <= '0;
      r_exmem_rd     <= '0;
      r_exmem_result <= '0;
      r_exmem_addr   <= '0;
      r_exmem_div0   <= 1'b0;
      r_memwb_valid  <= 1'b0;
      r_memwb_op     <= '0;
      r_memwb_rd     <= '0;
      r_memwb_result <= '0;
      r_memwb_div0   <= 1'b0;
      r_zero         <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      if (!w_loadUse) begin
        r_ifid_valid <= instr_valid;
        r_ifid_instr <= instr;
      end
      r_idex_valid   <= r_ifid_valid && !w_loadUse;
      r_idex_op      <= w_op;
      r_idex_rd      <= w_rd;
      r_idex_srcA    <= w_srcA;
      r_idex_srcB    <= w_rs2;
      r_idex_valA    <= w_rfA;
      r_idex_valB    <= w_rfB;
      r_idex_imm     <= w_immVal;
      r_idex_aluOp   <= w_aluOp;
      r_idex_useImm  <= w_useImm;
      r_idex_addr    <= w_imm[MEM_AW-1:0];
      r_exmem_valid  <= r_idex_valid;
      r_exmem_op     <= r_idex_op;
      r_exmem_rd     <= r_idex_rd;
      r_exmem_result <= w_aluRes;
      r_exmem_addr   <= r_idex_addr;
      r_exmem_div0   <= w_aluDiv0 && isAluOp(r_idex_op);
      r_memwb_valid  <= r_exmem_valid;
      r_memwb_op     <= r_exmem_op;
      r_memwb_rd     <= r_exmem_rd;
      r_memwb_result <= r_exmem_result;
      r_memwb_div0   <= r_exmem_div0;
      if (r_memwb_valid && isAluOp(r_memwb_op))
        r_zero <= (r_memwb_result == '0);
      if (r_memwb_valid && r_memwb_div0)
        r_error <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        r_regs[i] <= '0;
    end else if (w_wbWrite) begin
      r_regs[r_memwb_rd] <= w_wbData;
    end
  end

endmodule

// File: tb/tb_pipelined_datapath_fwd.sv
// Directed-vector bench for pipelined_datapath_fwd with a synchronous memory
// model and a retire/stall/store monitor; expected values are hand-computed.
module tb_pipelined_datapath_fwd;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        mem_we, mem_re;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        retire_valid;
  logic [3:0]  retire_rd;
  logic [15:0] retire_data;
  logic        zero_flag, error_flag, stall;

  int vecCount  = 0;
  int missCount = 0;
  int cycleCnt  = 0;
  int stallCnt  = 0;
  int weCnt     = 0;
  int acceptCyc = 0;
  logic [7:0]  weAddr;
  logic [15:0] weData;
  logic [3:0]  retRd [$];
  logic [15:0] retData [$];
  int          retCyc [$];
  logic [15:0] mem [0:255];

  pipelined_datapath_fwd dut (
    .clock        (clock),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .retire_valid (retire_valid),
    .retire_rd    (retire_rd),
    .retire_data  (retire_data),
    .zero_flag    (zero_flag),
    .error_flag   (error_flag),
    .stall        (stall)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  // Synchronous data memory: read data appears the cycle after mem_re
  always @(posedge clock) begin
    if (reset) mem[8'h10] <= 16'h1234;
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  always @(negedge clock) begin
    if (retire_valid) begin
      retRd.push_back(retire_rd);
      retData.push_back(retire_data);
      retCyc.push_back(cycleCnt);
    end
    if (stall) stallCnt++;
    if (mem_we) begin
      weCnt++;
      weAddr = mem_addr;
      weData = mem_wdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Holds the instruction until the handshake completes, bounded
  task automatic applyStimulus(input logic [15:0] ins);
    bit ok;
    ok = 1'b0;
    instr = ins;
    instr_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clock);
      ok = instr_ready;
      if (ok) acceptCyc = cycleCnt;
      @(posedge clock);
      #1;
    end
    if (!ok) checkOutput("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clearLog();
    retRd.delete();
    retData.delete();
    retCyc.delete();
    stallCnt = 0;
    weCnt = 0;
  endtask

  function automatic int cycAt(input int idx);
    return (idx < retCyc.size()) ? retCyc[idx] : -100;
  endfunction

  task automatic checkRetire(input int idx, input logic [3:0] rd, input logic [15:0] data, input string tag);
    logic [3:0]  r;
    logic [15:0] d;
    r = 4'hx;
    d = 16'hxxxx;
    if (idx < retRd.size()) begin
      r = retRd[idx];
      d = retData[idx];
    end
    checkOutput({tag, "_rd"}, 32'(r), 32'(rd));
    checkOutput({tag, "_data"}, 32'(d), 32'(data));
  endtask

  initial begin
    int firstAccept;
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_ready", 32'(instr_ready), 32'd0);
    checkOutput("rst_retire", 32'(retire_valid), 32'd0);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_flags", 32'({zero_flag, error_flag}), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("ready_after_reset", 32'(instr_ready), 32'd1);
    @(posedge clock);
    #1;

    // Back-to-back dependent ALU ops exercise both forwarding paths
    clearLog();
    applyStimulus(16'h2105);
    firstAccept = acceptCyc;
    applyStimulus(16'h2203);
    applyStimulus(16'hA312);
    applyStimulus(16'hB431);
    idle(8);
    checkOutput("t1_count", 32'(retRd.size()), 32'd4);
    checkOutput("t1_latency", 32'(cycAt(0) - firstAccept), 32'd4);
    checkRetire(0, 4'd1, 16'd5, "t1_ldr");
    checkRetire(2, 4'd3, 16'd8, "t1_add");
    checkRetire(3, 4'd4, 16'd3, "t1_sub");
    checkOutput("t1_spacing", 32'(cycAt(3) - cycAt(2)), 32'd1);
    checkOutput("t1_stall", 32'(stallCnt), 32'd0);
    checkOutput("t1_zero", 32'(zero_flag), 32'd0);

    // Load-use: one bubble, then forward from WB
    clearLog();
    applyStimulus(16'h0110);
    applyStimulus(16'hA211);
    idle(8);
    checkOutput("t2_count", 32'(retRd.size()), 32'd2);
    checkRetire(0, 4'd1, 16'h1234, "t2_ldm");
    checkRetire(1, 4'd2, 16'h2468, "t2_add");
    checkOutput("t2_spacing", 32'(cycAt(1) - cycAt(0)), 32'd2);
    checkOutput("t2_stall", 32'(stallCnt), 32'd1);

    // Store with forwarded data, then reload it
    clearLog();
    applyStimulus(16'h2109);
    applyStimulus(16'h1120);
    applyStimulus(16'h0520);
    idle(8);
    checkOutput("t3_we_count", 32'(weCnt), 32'd1);
    checkOutput("t3_we_addr", 32'(weAddr), 32'h20);
    checkOutput("t3_we_data", 32'(weData), 32'd9);
    checkRetire(1, 4'd0, 16'd0, "t3_stm");
    checkRetire(2, 4'd5, 16'd9, "t3_reload");

    // Divide by zero, sticky error, zero flag on a zero result
    clearLog();
    applyStimulus(16'h2100);
    applyStimulus(16'h2207);
    applyStimulus(16'hC321);
    idle(8);
    checkRetire(2, 4'd3, 16'hFFFF, "t4_div");
    checkOutput("t4_error", 32'(error_flag), 32'd1);
    checkOutput("t4_zero_div", 32'(zero_flag), 32'd0);
    clearLog();
    applyStimulus(16'h2401);
    applyStimulus(16'hB644);
    idle(8);
    checkRetire(1, 4'd6, 16'd0, "t4_sub0");
    checkOutput("t4_error_sticky", 32'(error_flag), 32'd1);
    checkOutput("t4_zero_set", 32'(zero_flag), 32'd1);

    // Shifts (logical/arithmetic) and both not variants
    clearLog();
    applyStimulus(16'h2180);
    applyStimulus(16'h8117);
    applyStimulus(16'h8111);
    applyStimulus(16'h9219);
    applyStimulus(16'h9311);
    applyStimulus(16'h742F);
    applyStimulus(16'h7520);
    idle(8);
    checkRetire(1, 4'd1, 16'h4000, "t5_shl7");
    checkRetire(2, 4'd1, 16'h8000, "t5_shl1");
    checkRetire(3, 4'd2, 16'hC000, "t5_sra");
    checkRetire(4, 4'd3, 16'h4000, "t5_srl");
    checkRetire(5, 4'd4, 16'h4000, "t5_neg");
    checkRetire(6, 4'd5, 16'h3FFF, "t5_not");
    checkOutput("t5_zero", 32'(zero_flag), 32'd0);

    // Mid-flight reset flushes the pipe and clears state
    clearLog();
    applyStimulus(16'h2711);
    applyStimulus(16'h2822);
    applyStimulus(16'h2933);
    applyStimulus(16'h2A44);
    instr_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(6);
    checkOutput("t6_no_retire", 32'(retRd.size()), 32'd0);
    checkOutput("t6_error_clr", 32'(error_flag), 32'd0);
    checkOutput("t6_zero_clr", 32'(zero_flag), 32'd0);
    clearLog();
    applyStimulus(16'h3920);
    applyStimulus(16'hA833);
    idle(8);
    checkOutput("t6_count", 32'(retRd.size()), 32'd2);
    checkRetire(0, 4'd9, 16'd0, "t6_mov");
    checkRetire(1, 4'd8, 16'd0, "t6_add");
    checkOutput("t6_zero", 32'(zero_flag), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
